mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the IF-stage instruction fetch and the MEM-stage load/store.
- Sequences each access over a fixed-latency RAM and returns data with a one-cycle ready pulse.
- Emits per-stage stall requests that the hazard/stall logic ORs with the load-use stall.
- Data port has priority: it belongs to the older instruction.

Parameters:
MEM_LATENCY, 2, cycles from the ram_en cycle to valid ram_rdata (legal 1..15)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  instruction fetch request
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1
if_ready  out  1  fetch-complete pulse
mem_rd  in  1  load request
mem_wr  in  1  store request
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, valid while mem_ready=1
mem_ready  out  1  data-access-complete pulse
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable, qualified by ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
stall_if  out  1  IF must hold
stall_mem  out  1  MEM and all older stages must hold

Behaviour:
- States: IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I. Down-counter cnt is 4 bits.
- Reset (reset=0, any cycle, including mid-access):
  - state=IDLE; cnt=0.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0.
  - The in-flight access is abandoned and no ready pulse is issued.
- Data request: mem_rd|mem_wr. If both are high, it is a write.
- Requester handshake: hold req, addr and wdata stable until its ready pulse is seen. Deassert req or change request in the cycle after the pulse.
- Grant (from IDLE):
  - Data request pending -> BUSY_D, else if_req -> BUSY_I.
  - On grant edge: latch addr (and wdata/we for data); ram_en=1 for exactly one cycle; cnt=MEM_LATENCY.
- BUSY: ram_addr, ram_wdata, ram_we held; ram_en=0 after the first cycle; cnt decrements each cycle.
- Completion: in the cycle cnt==0, ram_rdata is captured into if_rdata/mem_rdata; the next state is DONE_x.
- DONE_x: the matching ready=1 for one cycle; rdata holds the captured value.
  - Stores also pulse mem_ready; mem_rdata is unchanged on a store.
- Leaving DONE_x:
  - DONE_D: if_req pending -> grant IF (BUSY_I), else IDLE.
  - DONE_I: data request pending -> grant data (BUSY_D), else IDLE.
  - The requester just served is never granted from its own DONE state. This guarantees no double service while its req is still high.
- Latency: request-to-ready is MEM_LATENCY+2 cycles for an uncontended access. Worst case when contended is twice that.
- stall_if = if_req & ~if_ready; stall_mem = (mem_rd|mem_wr) & ~mem_ready. Both are combinational.
- if_rdata and mem_rdata hold their last captured value between accesses.
- No RAM access is issued without a pending request.
- ram_en and the ready outputs never assert in the same cycle for the same requester.

Test Plan:
1. Reset, MEM_LATENCY=2, mem_rd=1, mem_addr=0x100, RAM returns 0xDEADBEEF -> ram_en=1 only in cycle 1 with ram_addr=0x100, ram_we=0; mem_ready pulses in cycle 4 with mem_rdata=0xDEADBEEF; stall_mem=1 in cycles 0-3.
2. Simultaneous if_req (addr 0x0) and mem_wr (addr 0x40, wdata 0x1234) -> store granted first with ram_we=1 and ram_wdata=0x1234, then mem_ready; IF is granted directly from DONE_D with no IDLE cycle; if_ready follows; stall_if stays high until then.
3. Continuous if_req with changing addresses 0x0, 0x4, 0x8 -> each completes with exactly one if_ready pulse, one DONE->IDLE bubble between them, no duplicated fetch.
4. mem_rd=1 and mem_wr=1 together -> treated as a write (ram_we=1), mem_rdata unchanged.
5. reset asserted during BUSY_D with cnt=1 -> outputs zero immediately (asynchronous); no mem_ready after release; a fresh request after release completes normally.
6. MEM_LATENCY=1 and MEM_LATENCY=15 builds -> ready occurs 3 and 17 cycles after request, respectively.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port fixed-latency RAM between instruction fetch (IF) and load/store (MEM); data side wins.
// Latency: request to ready pulse is MEM_LATENCY+2 cycles uncontended, up to twice that when the other side goes first.
// Backpressure: a requester holds req/addr/wdata until its one-cycle ready pulse; stall_if/stall_mem stay high until that pulse.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_D = 3'd1,
    BUSY_I = 3'd2,
    DONE_D = 3'd3,
    DONE_I = 3'd4
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

  logic data_req;
  logic grant_d;
  logic grant_i;

  // A store wins when both load and store are raised together.
  assign data_req = mem_rd | mem_wr;

  // Next-state: grant from IDLE or from the other side's DONE, count down the RAM latency, capture read data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_en_d    = 1'b0;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    grant_d     = 1'b0;
    grant_i     = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_req) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_i = 1'b1;
        end
      end
      BUSY_D: begin
        if (cnt_q == 4'd0) begin
          // Stores complete too, but leave the last load value in place.
          if (!ram_we_q) begin
            mem_rdata_d = ram_rdata;
          end
          state_d = DONE_D;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BUSY_I: begin
        if (cnt_q == 4'd0) begin
          if_rdata_d = ram_rdata;
          state_d    = DONE_I;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // The side just served still has its request up this cycle, so only the other side may be granted here.
      DONE_D: begin
        if (if_req) begin
          grant_i = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DONE_I: begin
        if (data_req) begin
          grant_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_d) begin
      state_d     = BUSY_D;
      cnt_d       = CNT_INIT;
      ram_en_d    = 1'b1;
      ram_we_d    = mem_wr;
      ram_addr_d  = mem_addr;
      ram_wdata_d = mem_wdata;
    end else if (grant_i) begin
      state_d    = BUSY_I;
      cnt_d      = CNT_INIT;
      ram_en_d   = 1'b1;
      ram_we_d   = 1'b0;
      ram_addr_d = if_addr;
    end
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Ready pulses come straight from the DONE states; stalls drop in the ready cycle.
  always_comb begin
    ram_en    = ram_en_q;
    ram_we    = ram_we_q;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    if_rdata  = if_rdata_q;
    mem_rdata = mem_rdata_q;
    if_ready  = (state_q == DONE_I);
    mem_ready = (state_q == DONE_D);
    stall_if  = if_req & ~if_ready;
    stall_mem = data_req & ~mem_ready;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter with a behavioural fixed-latency RAM.
// Latency: expected RAM strobes and ready pulses are queued with the cycle they are due in.
// Backpressure: requesters hold until their ready pulse, then drop the next cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ML = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        stall_if;
  logic        stall_mem;

  mem_port_arbiter #(.MEM_LATENCY(ML), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // Latency-only instances at the extreme legal latencies.
  logic        l1_rd, l15_rd, lz1;
  logic [31:0] lz32, lram_rdata;
  logic [31:0] l1_if_rdata, l1_mem_rdata, l1_ram_addr, l1_ram_wdata;
  logic        l1_if_ready, l1_mem_ready, l1_ram_en, l1_ram_we, l1_stall_if, l1_stall_mem;
  logic [31:0] l15_if_rdata, l15_mem_rdata, l15_ram_addr, l15_ram_wdata;
  logic        l15_if_ready, l15_mem_ready, l15_ram_en, l15_ram_we, l15_stall_if, l15_stall_mem;

  assign lz1        = 1'b0;
  assign lz32       = 32'h0;
  assign lram_rdata = 32'h6000_0001;

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(lz1), .if_addr(lz32), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
    .mem_rd(l1_rd), .mem_wr(lz1), .mem_addr(lz32), .mem_wdata(lz32),
    .mem_rdata(l1_mem_rdata), .mem_ready(l1_mem_ready),
    .ram_en(l1_ram_en), .ram_we(l1_ram_we), .ram_addr(l1_ram_addr), .ram_wdata(l1_ram_wdata),
    .ram_rdata(lram_rdata), .stall_if(l1_stall_if), .stall_mem(l1_stall_mem)
  );

  mem_port_arbiter #(.MEM_LATENCY(15), .ADDR_W(32), .DATA_W(32)) dut_l15 (
    .clk(clk), .reset(reset),
    .if_req(lz1), .if_addr(lz32), .if_rdata(l15_if_rdata), .if_ready(l15_if_ready),
    .mem_rd(l15_rd), .mem_wr(lz1), .mem_addr(lz32), .mem_wdata(lz32),
    .mem_rdata(l15_mem_rdata), .mem_ready(l15_mem_ready),
    .ram_en(l15_ram_en), .ram_we(l15_ram_we), .ram_addr(l15_ram_addr), .ram_wdata(l15_ram_wdata),
    .ram_rdata(lram_rdata), .stall_if(l15_stall_if), .stall_mem(l15_stall_mem)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: read data appears ML cycles after the strobe; garbage otherwise.
  logic [31:0] ram [0:255];
  logic [31:0] rpipe [0:ML-1];
  always @(posedge clk) begin
    if (ram_en && ram_we) ram[ram_addr[9:2]] <= ram_wdata;
    rpipe[0] <= ram_en ? ram[ram_addr[9:2]] : 32'h0BAD_0BAD;
    for (int i = 1; i < ML; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[ML-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] rdata; int due; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int due; } ramx_t;

  rsp_t  sb_if[$];
  rsp_t  sb_mem[$];
  ramx_t sb_ram[$];
  rsp_t  mon_rsp;
  ramx_t mon_ram;

  // Scoreboard: every RAM strobe and ready pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (ram_en) begin
        if (sb_ram.size() == 0) chk("ram_en_unexpected", 32'(ram_en), 32'd0);
        else begin
          mon_ram = sb_ram.pop_front();
          chk("ram_en_cycle", cyc, mon_ram.due);
          chk("ram_we", 32'(ram_we), 32'(mon_ram.we));
          chk("ram_addr", ram_addr, mon_ram.addr);
          if (mon_ram.we) chk("ram_wdata", ram_wdata, mon_ram.wdata);
        end
      end
      if (mem_ready) begin
        if (sb_mem.size() == 0) chk("mem_ready_unexpected", 32'(mem_ready), 32'd0);
        else begin
          mon_rsp = sb_mem.pop_front();
          chk("mem_ready_cycle", cyc, mon_rsp.due);
          chk("mem_rdata", mem_rdata, mon_rsp.rdata);
        end
      end
      if (if_ready) begin
        if (sb_if.size() == 0) chk("if_ready_unexpected", 32'(if_ready), 32'd0);
        else begin
          mon_rsp = sb_if.pop_front();
          chk("if_ready_cycle", cyc, mon_rsp.due);
          chk("if_rdata", if_rdata, mon_rsp.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold requests until their ready pulse, drop them the cycle after.
  task automatic service(input int budget);
    int n;
    logic mr, ir;
    n = 0;
    while ((mem_rd || mem_wr || if_req) && n < budget) begin
      mr = mem_ready;
      ir = if_ready;
      tick();
      n++;
      if (mr) begin mem_rd = 1'b0; mem_wr = 1'b0; end
      if (ir) if_req = 1'b0;
    end
    chk("service_done", 32'(mem_rd | mem_wr | if_req), 32'd0);
  endtask

  typedef struct {
    logic        is_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vec [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, lat1, lat15, pulses;

    vec[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h1000_0000};
    vec[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h1000_0001};
    vec[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h1000_0002};
    vec[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF};
    vec[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h5555_AAAA, 32'hDEAD_BEEF};
    vec[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_1234};
    vec[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h0000_1234};
    vec[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D};
    vec[8] = '{1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h5555_AAAA};
    vec[9] = '{1'b0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0, 32'h1000_00FF};

    for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 | 32'(i);
    ram[8'h40] = 32'hDEAD_BEEF;

    reset = 1'b0; if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_wdata = '0; l1_rd = 1'b0; l15_rd = 1'b0;

    // Reset state.
    tick(); tick();
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_ready", 32'({if_ready, mem_ready}), 32'd0);
    chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
    chk("rst_stall", 32'({stall_if, stall_mem}), 32'd0);
    reset = 1'b1;

    // Uncontended load with per-cycle strobe/stall/ready checks.
    c = cyc;
    mem_rd = 1'b1; mem_addr = 32'h100;
    sb_ram.push_back('{1'b0, 32'h100, 32'h0, c + 1});
    sb_mem.push_back('{32'hDEAD_BEEF, c + ML + 2});
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #1;
      chk($sformatf("t1_ram_en_k%0d", k), 32'(ram_en), 32'(k == 1));
      chk($sformatf("t1_mem_ready_k%0d", k), 32'(mem_ready), 32'(k == 4));
      chk($sformatf("t1_stall_mem_k%0d", k), 32'(stall_mem), 32'(k <= 3));
    end
    tick(); mem_rd = 1'b0;

    // Simultaneous fetch and store: store first, fetch granted straight from DONE_D.
    c = cyc;
    if_req = 1'b1; if_addr = 32'h0;
    mem_wr = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h1234;
    sb_ram.push_back('{1'b1, 32'h40, 32'h1234, c + 1});
    sb_ram.push_back('{1'b0, 32'h0, 32'h0, c + 5});
    sb_mem.push_back('{32'hDEAD_BEEF, c + 4});
    sb_if.push_back('{32'h1000_0000, c + 8});
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      if (k == 5) mem_wr = 1'b0;
      #1;
      chk($sformatf("t2_ram_en_k%0d", k), 32'(ram_en), 32'(k == 1 || k == 5));
      chk($sformatf("t2_mem_ready_k%0d", k), 32'(mem_ready), 32'(k == 4));
      chk($sformatf("t2_if_ready_k%0d", k), 32'(if_ready), 32'(k == 8));
      chk($sformatf("t2_stall_if_k%0d", k), 32'(stall_if), 32'(k <= 7));
      chk($sformatf("t2_stall_mem_k%0d", k), 32'(stall_mem), 32'(k <= 3));
    end
    tick(); if_req = 1'b0;

    // Table-driven back-to-back accesses (new request raised in the bubble cycle).
    for (int i = 0; i < 10; i++) begin
      c = cyc;
      if (vec[i].is_if) begin
        if_req = 1'b1; if_addr = vec[i].addr;
        sb_ram.push_back('{1'b0, vec[i].addr, 32'h0, c + 1});
        sb_if.push_back('{vec[i].exp, c + ML + 2});
      end else begin
        mem_rd = vec[i].rd; mem_wr = vec[i].wr;
        mem_addr = vec[i].addr; mem_wdata = vec[i].wdata;
        sb_ram.push_back('{vec[i].wr, vec[i].addr, vec[i].wdata, c + 1});
        sb_mem.push_back('{vec[i].exp, c + ML + 2});
      end
      service(40);
    end

    // Reset in BUSY_D with cnt=1: outputs clear at once, no late ready.
    c = cyc;
    mem_rd = 1'b1; mem_addr = 32'h100;
    sb_ram.push_back('{1'b0, 32'h100, 32'h0, c + 1});
    tick(); tick();
    #2; reset = 1'b0; #1;
    chk("t5_ram_en", 32'(ram_en), 32'd0);
    chk("t5_ram_addr", ram_addr, 32'd0);
    chk("t5_ram_we_wdata", ram_wdata | 32'(ram_we), 32'd0);
    chk("t5_mem_rdata", mem_rdata, 32'd0);
    chk("t5_if_rdata", if_rdata, 32'd0);
    chk("t5_ready", 32'({if_ready, mem_ready}), 32'd0);
    mem_rd = 1'b0;
    tick(); tick();
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (mem_ready || if_ready) pulses++;
    end
    chk("t5_no_ready_after_reset", pulses, 0);

    // Fresh request after reset completes normally.
    c = cyc;
    mem_rd = 1'b1; mem_addr = 32'h100;
    sb_ram.push_back('{1'b0, 32'h100, 32'h0, c + 1});
    sb_mem.push_back('{32'hDEAD_BEEF, c + ML + 2});
    service(40);

    // Latency at MEM_LATENCY=1 and 15.
    c = cyc; lat1 = -1; lat15 = -1;
    l1_rd = 1'b1; l15_rd = 1'b1;
    for (int n = 1; n <= 40 && (l1_rd || l15_rd); n++) begin
      tick();
      if (lat1 >= 0) l1_rd = 1'b0;
      if (lat15 >= 0) l15_rd = 1'b0;
      if (l1_mem_ready && lat1 < 0) lat1 = cyc - c;
      if (l15_mem_ready && lat15 < 0) lat15 = cyc - c;
    end
    chk("t6_latency_1", lat1, 3);
    chk("t6_latency_15", lat15, 17);
    chk("t6_rdata_1", l1_mem_rdata, 32'h6000_0001);
    chk("t6_rdata_15", l15_mem_rdata, 32'h6000_0001);
    tick(); tick();
    chk("t6_idle_outputs", 32'(|{l1_if_rdata, l1_if_ready, l1_mem_ready, l1_ram_en, l1_ram_we,
                                  l1_ram_addr, l1_ram_wdata, l1_stall_if, l1_stall_mem,
                                  l15_if_rdata, l15_if_ready, l15_mem_ready, l15_ram_en, l15_ram_we,
                                  l15_ram_addr, l15_ram_wdata, l15_stall_if, l15_stall_mem}), 32'd0);

    tick(); tick();
    chk("sb_leftover", 32'(sb_if.size() + sb_mem.size() + sb_ram.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
